// File: rtl/add_sub_acc_pipe.sv
// Add/subtract/accumulate unit with saturation, status flags and a registered output stage.
// Latency: 1 cycle from transfer-in to out_valid_o.
// Backpressure: in_ready_o drops while a result is held and out_ready_i is low; outputs then hold.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid_i/in_ready_o  input handshake; a_i, b_i, op_i, signed_i, sat_i, clr_i qualified by it
//                       (clr_i also acts on its own, without a transfer)
//   out_valid_o/out_ready_i output handshake; result_o plus carry/ovf/zero/neg/sat flags
//   acc_o               current accumulator value
module add_sub_acc_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  input  logic             signed_i,
  input  logic             sat_i,
  input  logic             clr_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             neg_o,
  output logic             sat_o,
  output logic [WIDTH-1:0] acc_o
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q, acc_q;
  logic             carry_q, ovf_q, zero_q, neg_q, sat_q;

  logic             xfer_in, is_acc, is_sub;
  logic [WIDTH-1:0] x_op, y_op;
  logic [WIDTH:0]   raw;
  logic [WIDTH-1:0] result_d, acc_d;
  logic             carry_d, ovf_d, sat_d;

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign xfer_in    = in_valid_i && in_ready_o;
  assign is_acc     = op_i[1];
  assign is_sub     = op_i[0];

  // Accumulate ops use acc as X; a same-cycle clear makes that X zero.
  always_comb begin
    x_op = a_i;
    y_op = b_i;
    if (is_acc) begin
      x_op = clr_i ? '0 : acc_q;
      y_op = a_i;
    end
  end

  // Zero-extended so raw[WIDTH] is the unsigned carry (add) or borrow (sub).
  assign raw     = is_sub ? ({1'b0, x_op} - {1'b0, y_op})
                          : ({1'b0, x_op} + {1'b0, y_op});
  assign carry_d = raw[WIDTH];
  assign ovf_d   = (is_sub ? (x_op[MSB] != y_op[MSB]) : (x_op[MSB] == y_op[MSB]))
                   && (raw[MSB] != x_op[MSB]);

  always_comb begin
    result_d = raw[MSB:0];
    sat_d    = 1'b0;
    if (sat_i) begin
      if (signed_i) begin
        // Overflow always moves away from X's sign, so X picks the clamp rail.
        if (ovf_d) begin
          sat_d    = 1'b1;
          result_d = x_op[MSB] ? SMIN : SMAX;
        end
      end else if (carry_d) begin
        sat_d    = 1'b1;
        result_d = is_sub ? '0 : '1;
      end
    end
  end

  // An accumulate transfer wins over a plain clear; its X was already zeroed by clr_i.
  always_comb begin
    acc_d = acc_q;
    if (xfer_in && is_acc) begin
      acc_d = result_d;
    end else if (clr_i) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      sat_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      acc_q <= acc_d;
      if (xfer_in) begin
        out_valid_q <= 1'b1;
        result_q    <= result_d;
        carry_q     <= carry_d;
        ovf_q       <= ovf_d;
        zero_q      <= (result_d == '0);
        neg_q       <= result_d[MSB];
        sat_q       <= sat_d;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign carry_o     = carry_q;
  assign ovf_o       = ovf_q;
  assign zero_o      = zero_q;
  assign neg_o       = neg_q;
  assign sat_o       = sat_q;
  assign acc_o       = acc_q;

endmodule

// File: tb/tb_add_sub_acc_pipe.sv
module tb_add_sub_acc_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [7:0] a_i = '0, b_i = '0;
  logic [1:0] op_i = '0;
  logic       signed_i = 1'b0, sat_i = 1'b0, clr_i = 1'b0;
  logic       out_valid_o;
  logic       out_ready_i = 1'b1;
  logic [7:0] result_o, acc_o;
  logic       carry_o, ovf_o, zero_o, neg_o, sat_o;

  add_sub_acc_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .op_i(op_i),
    .signed_i(signed_i), .sat_i(sat_i), .clr_i(clr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .carry_o(carry_o), .ovf_o(ovf_o),
    .zero_o(zero_o), .neg_o(neg_o), .sat_o(sat_o), .acc_o(acc_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic       c, v, z, n, s;
    logic [7:0] acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted result is compared with the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      exp_t e, got;
      got = '{res: result_o, c: carry_o, v: ovf_o, z: zero_o, n: neg_o, s: sat_o, acc: acc_o};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got res=0x%0h with no expectation queued", result_o);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL result: got res=%0h c=%b v=%b z=%b n=%b s=%b acc=%0h, expected res=%0h c=%b v=%b z=%b n=%b s=%b acc=%0h",
                   got.res, got.c, got.v, got.z, got.n, got.s, got.acc,
                   e.res, e.c, e.v, e.z, e.n, e.s, e.acc);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                      input logic sgn, input logic sat, input logic clr,
                      input logic [7:0] e_res, input logic [4:0] e_cvzns, input logic [7:0] e_acc);
    int waited;
    a_i = a; b_i = b; op_i = op; signed_i = sgn; sat_i = sat; clr_i = clr;
    in_valid_i = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready_o && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready_o) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready_o stayed 0, expected 1");
    end else begin
      exp_q.push_back('{res: e_res, c: e_cvzns[4], v: e_cvzns[3], z: e_cvzns[2],
                        n: e_cvzns[1], s: e_cvzns[0], acc: e_acc});
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    clr_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state before any clock edge.
    #2;
    check("reset_valid", out_valid_o, 0);
    check("reset_result", result_o, 0);
    check("reset_acc", acc_o, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ready_after_reset", in_ready_o, 1);
    @(posedge clk); #1;

    // flags order: {carry, ovf, zero, neg, sat}
    send(8'd200, 8'd100, 2'b00, 0, 0, 0, 8'd44,  5'b10000, 8'd0);
    send(8'd200, 8'd100, 2'b00, 0, 1, 0, 8'd255, 5'b10011, 8'd0);
    send(8'd100, 8'd50,  2'b00, 1, 0, 0, 8'h96,  5'b01010, 8'd0);
    send(8'd100, 8'd50,  2'b00, 1, 1, 0, 8'h7F,  5'b01001, 8'd0);
    send(8'h80,  8'hFF,  2'b00, 1, 1, 0, 8'h80,  5'b11011, 8'd0);
    send(8'd10,  8'd20,  2'b01, 0, 0, 0, 8'd246, 5'b10010, 8'd0);
    send(8'd10,  8'd20,  2'b01, 0, 1, 0, 8'd0,   5'b10101, 8'd0);

    // Stand-alone clear, then accumulate 5, +7, -3.
    clr_i = 1'b1;
    idle(1);
    clr_i = 1'b0;
    send(8'd5, 8'd0, 2'b10, 0, 0, 0, 8'd5,  5'b00000, 8'd5);
    send(8'd7, 8'd0, 2'b10, 0, 0, 0, 8'd12, 5'b00000, 8'd12);
    send(8'd3, 8'd0, 2'b11, 0, 0, 0, 8'd9,  5'b00000, 8'd9);
    idle(2);
    check("acc_after_seq", acc_o, 9);

    // Backpressure: first result held, second operand ignored for 5 cycles.
    out_ready_i = 1'b0;
    send(8'd1, 8'd2, 2'b00, 0, 0, 0, 8'd3, 5'b00000, 8'd9);
    a_i = 8'd3; b_i = 8'd3; op_i = 2'b01; in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready_o, 0);
      check("stall_valid", out_valid_o, 1);
      check("stall_result", result_o, 3);
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    send(8'd3, 8'd3, 2'b01, 0, 0, 0, 8'd0, 5'b00100, 8'd9);

    // Clear concurrent with an accumulate: X is 0, acc takes the new result.
    send(8'd4, 8'd0, 2'b10, 0, 0, 1, 8'd4, 5'b00000, 8'd4);
    idle(3);
    check("all_consumed", exp_q.size(), 0);
    check("acc_after_clr_acc", acc_o, 4);

    // Build acc=9 with the result held, then reset asynchronously.
    out_ready_i = 1'b0;
    send(8'd5, 8'd0, 2'b10, 0, 0, 0, 8'd9, 5'b00000, 8'd9);
    check("pre_reset_valid", out_valid_o, 1);
    check("pre_reset_acc", acc_o, 9);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid_o, 0);
    check("async_rst_result", result_o, 0);
    check("async_rst_acc", acc_o, 0);
    check("async_rst_flags", {carry_o, ovf_o, zero_o, neg_o, sat_o}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready_i = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
